// File: rtl/prng_pkg.sv
// Shared types and helpers for the prng_sched block: FSM state encoding,
// default PRNG word width and burst-length decoding.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } prng_sched_state_t;

    localparam int unsigned PRNG_DW  = 32;
    localparam int unsigned LEN_MAXW = 16;

    // A zero length field encodes the maximum burst of 2^lenw words.
    function automatic logic [LEN_MAXW:0] len_decode(input logic [LEN_MAXW-1:0] len,
                                                     input int unsigned lenw);
        logic [LEN_MAXW:0] one;
        one = {{LEN_MAXW{1'b0}}, 1'b1};
        return (len == '0) ? (one << lenw) : {1'b0, len};
    endfunction

endpackage

// File: rtl/prng_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [31:0]   j;
    logic [IW-1:0] jj;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        jj    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j  = (32'(rr_ptr) + i) % NREQ;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/prng_sched.sv
// Round-robin scheduler sharing one PRNG among NREQ burst consumers.
// Define PRNG_SCHED_DISCARD_EN to burn one PRNG word between bursts.
module prng_sched
    import prng_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = PRNG_DW,
    parameter int unsigned LENW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        prng_dout,
    output logic                 prng_adv,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      gnt,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic [NREQ-1:0]      out_ready,
    output logic                 out_last
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = LENW + 1;

    prng_sched_state_t state, state_d;

    logic [IW-1:0]   idx, rr_ptr, arb_idx;
    logic [NREQ-1:0] arb_gnt, gnt_q;
    logic [CW-1:0]   cnt;
    logic            sel_ready, last, xfer, start;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .rr_ptr(rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    assign sel_ready = out_ready[idx];
    assign last      = (cnt == CW'(1));
    assign xfer      = (state == BURST) && sel_ready;
    assign start     = (state == IDLE) && (|req);
    assign out_data  = prng_dout;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (|req) state_d = BURST;
            BURST: if (xfer && last) begin
`ifdef PRNG_SCHED_DISCARD_EN
                state_d = GAP;
`else
                state_d = IDLE;
`endif
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latch, burst counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            gnt_q  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else if (start) begin
            idx   <= arb_idx;
            gnt_q <= arb_gnt;
            cnt   <= CW'(len_decode(LEN_MAXW'(req_len[arb_idx*LENW +: LENW]), LENW));
        end else if (xfer) begin
            cnt <= cnt - CW'(1);
            if (last) rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Output decode
    always_comb begin
        gnt       = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        prng_adv  = 1'b0;
        case (state)
            BURST: begin
                gnt       = gnt_q;
                out_valid = 1'b1;
                out_last  = last;
                prng_adv  = sel_ready;
            end
            GAP:     prng_adv = 1'b1;
            default: ;
        endcase
    end

endmodule
